// File: rtl/cp0_regfile.sv
// rtl/cp0_regfile.sv - MIPS CP0 subset: BadVAddr/Count/Compare/Status/Cause/EPC, timer, exception entry and ERET.
// Optional PRId/Config read-only registers are enabled by defining CP0_PRID_CONFIG_EN.
module cp0_regfile #(
  parameter int          HW_INT_NUM = 6,
  parameter int          COUNT_DIV  = 2,
  parameter logic [31:0] EXC_VECTOR = 32'hBFC00380
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  wen,
  input  logic [7:0]            addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata,
  input  logic [HW_INT_NUM-1:0] hw_int,
  input  logic                  exc_valid,
  input  logic [4:0]            exc_code,
  input  logic                  exc_bd,
  input  logic [31:0]           exc_pc,
  input  logic [31:0]           exc_badvaddr,
  input  logic                  exc_badvaddr_valid,
  input  logic                  eret,
  output logic                  int_pending,
  output logic                  flush,
  output logic [31:0]           exc_target,
  output logic                  status_exl
);

  localparam logic [7:0] A_BADVADDR = {5'd8, 3'd0};
  localparam logic [7:0] A_COUNT    = {5'd9, 3'd0};
  localparam logic [7:0] A_COMPARE  = {5'd11, 3'd0};
  localparam logic [7:0] A_STATUS   = {5'd12, 3'd0};
  localparam logic [7:0] A_CAUSE    = {5'd13, 3'd0};
  localparam logic [7:0] A_EPC      = {5'd14, 3'd0};
  localparam logic [3:0] DIV_LAST   = 4'(COUNT_DIV - 1);

  logic [31:0] badvaddr, count, compare, epc;
  logic [7:0]  status_im;
  logic        status_ie;
  logic        cause_bd, cause_ti;
  logic [1:0]  cause_ip_sw;
  logic [4:0]  cause_exccode;
  logic [5:0]  hw_ip, hw_ext;
  logic [3:0]  div_cnt;
  logic [7:0]  cause_ip;
  logic        sw_wen, wr_count, wr_compare;

  always_comb begin
    hw_ext = '0;
    hw_ext[HW_INT_NUM-1:0] = hw_int;
  end

  // Lines above HW_INT_NUM sample as 0, so IP7 reduces to TI alone for narrower configs.
  assign cause_ip   = {hw_ip[5] | cause_ti, hw_ip[4:0], cause_ip_sw};
  assign sw_wen     = wen & ~exc_valid & ~eret;
  assign wr_count   = sw_wen && (addr == A_COUNT);
  assign wr_compare = sw_wen && (addr == A_COMPARE);

  assign int_pending = status_ie & ~status_exl & (|(cause_ip & status_im));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      badvaddr      <= '0;
      count         <= '0;
      compare       <= '0;
      epc           <= '0;
      status_im     <= '0;
      status_exl    <= 1'b0;
      status_ie     <= 1'b0;
      cause_bd      <= 1'b0;
      cause_ti      <= 1'b0;
      cause_ip_sw   <= '0;
      cause_exccode <= '0;
      hw_ip         <= '0;
      div_cnt       <= '0;
      flush         <= 1'b0;
      exc_target    <= '0;
    end else begin
      hw_ip <= hw_ext;

      if (wr_count) begin
        count   <= wdata;
        div_cnt <= '0;
      end else if (div_cnt == DIV_LAST) begin
        count   <= count + 32'd1;
        div_cnt <= '0;
      end else begin
        div_cnt <= div_cnt + 4'd1;
      end

      if (wr_compare) begin
        compare  <= wdata;
        cause_ti <= 1'b0;
      end else if (count == compare) begin
        cause_ti <= 1'b1;
      end

      flush <= 1'b0;
      if (exc_valid) begin
        if (!status_exl) begin
          epc      <= exc_bd ? exc_pc - 32'd4 : exc_pc;
          cause_bd <= exc_bd;
        end
        cause_exccode <= exc_code;
        status_exl    <= 1'b1;
        if (exc_badvaddr_valid) badvaddr <= exc_badvaddr;
        flush      <= 1'b1;
        exc_target <= EXC_VECTOR;
      end else if (eret) begin
        status_exl <= 1'b0;
        flush      <= 1'b1;
        exc_target <= epc;
      end else if (sw_wen) begin
        case (addr)
          A_STATUS: begin
            status_im  <= wdata[15:8];
            status_exl <= wdata[1];
            status_ie  <= wdata[0];
          end
          A_CAUSE: cause_ip_sw <= wdata[9:8];
          A_EPC:   epc         <= wdata;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    rdata = '0;
    case (addr)
      A_BADVADDR: rdata = badvaddr;
      A_COUNT:    rdata = count;
      A_COMPARE:  rdata = compare;
      A_STATUS:   rdata = {9'd0, 1'b1, 6'd0, status_im, 6'd0, status_exl, status_ie};
      A_CAUSE:    rdata = {cause_bd, cause_ti, 14'd0, cause_ip, 1'b0, cause_exccode, 2'b00};
      A_EPC:      rdata = epc;
`ifdef CP0_PRID_CONFIG_EN
      {5'd15, 3'd0}: rdata = 32'h0000_4220;
      {5'd16, 3'd0}: rdata = 32'h8000_0483;
`endif
      default:    rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_cp0_regfile.sv
// tb/tb_cp0_regfile.sv - directed and randomized checks of cp0_regfile against a behavioural model.
module tb_cp0_regfile;

  localparam int          HW_INT_NUM = 6;
  localparam int          COUNT_DIV  = 2;
  localparam logic [31:0] EXC_VECTOR = 32'hBFC00380;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        wen = 1'b0;
  logic [7:0]  addr = 8'h00;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic [5:0]  hw_int = '0;
  logic        exc_valid = 1'b0;
  logic [4:0]  exc_code = '0;
  logic        exc_bd = 1'b0;
  logic [31:0] exc_pc = '0;
  logic [31:0] exc_badvaddr = '0;
  logic        exc_badvaddr_valid = 1'b0;
  logic        eret = 1'b0;
  logic        int_pending, flush, status_exl;
  logic [31:0] exc_target;

  int n_tests = 0;
  int n_fail  = 0;

  cp0_regfile #(.HW_INT_NUM(HW_INT_NUM), .COUNT_DIV(COUNT_DIV), .EXC_VECTOR(EXC_VECTOR)) dut (
    .clk(clk), .resetn(resetn), .wen(wen), .addr(addr), .wdata(wdata), .rdata(rdata),
    .hw_int(hw_int), .exc_valid(exc_valid), .exc_code(exc_code), .exc_bd(exc_bd),
    .exc_pc(exc_pc), .exc_badvaddr(exc_badvaddr), .exc_badvaddr_valid(exc_badvaddr_valid),
    .eret(eret), .int_pending(int_pending), .flush(flush), .exc_target(exc_target),
    .status_exl(status_exl)
  );

  always #20 clk = ~clk;

  // Reference state: architectural fields, updated once per clock from the rules.
  logic [31:0] m_badv, m_count, m_cmp, m_epc, m_status, m_target;
  logic        m_bd, m_ti, m_flush;
  logic [1:0]  m_ipsw;
  logic [4:0]  m_code;
  logic [5:0]  m_hw;
  int          m_div;

  logic [31:0] n_badv, n_count, n_cmp, n_epc, n_status, n_target;
  logic        n_bd, n_ti, n_flush;
  logic [1:0]  n_ipsw;
  logic [4:0]  n_code;
  logic [5:0]  n_hw;
  int          n_div;

  task automatic m_reset();
    m_badv = 0; m_count = 0; m_cmp = 0; m_epc = 0; m_status = 32'h0040_0000; m_target = 0;
    m_bd = 0; m_ti = 0; m_flush = 0; m_ipsw = 0; m_code = 0; m_hw = 0; m_div = 0;
  endtask

  function automatic logic [31:0] m_cause();
    return {m_bd, m_ti, 14'd0, m_hw[5] | m_ti, m_hw[4:0], m_ipsw, 1'b0, m_code, 2'b00};
  endfunction

  function automatic logic [31:0] m_read(input logic [7:0] a);
    case (a)
      8'h40: return m_badv;
      8'h48: return m_count;
      8'h58: return m_cmp;
      8'h60: return m_status;
      8'h68: return m_cause();
      8'h70: return m_epc;
`ifdef CP0_PRID_CONFIG_EN
      8'h78: return 32'h0000_4220;
      8'h80: return 32'h8000_0483;
`endif
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic m_int();
    logic [31:0] c;
    c = m_cause();
    return m_status[0] & ~m_status[1] & (|(c[15:8] & m_status[15:8]));
  endfunction

  task automatic m_tick();
    logic sw;
    sw = wen && !exc_valid && !eret;
    n_badv = m_badv; n_cmp = m_cmp; n_epc = m_epc; n_status = m_status; n_target = m_target;
    n_bd = m_bd; n_ipsw = m_ipsw; n_code = m_code; n_flush = 0;
    n_hw = hw_int;
    if (sw && addr == 8'h48) begin
      n_count = wdata; n_div = 0;
    end else begin
      n_div = (m_div + 1) % COUNT_DIV;
      n_count = (n_div == 0) ? m_count + 1 : m_count;
    end
    if (sw && addr == 8'h58) begin
      n_cmp = wdata; n_ti = 0;
    end else begin
      n_ti = (m_count == m_cmp) ? 1'b1 : m_ti;
    end
    if (exc_valid) begin
      if (!m_status[1]) begin
        n_epc = exc_bd ? exc_pc - 4 : exc_pc;
        n_bd = exc_bd;
      end
      n_code = exc_code;
      n_status[1] = 1'b1;
      if (exc_badvaddr_valid) n_badv = exc_badvaddr;
      n_flush = 1; n_target = EXC_VECTOR;
    end else if (eret) begin
      n_status[1] = 1'b0;
      n_flush = 1; n_target = m_epc;
    end else if (sw) begin
      if (addr == 8'h60) n_status = (m_status & ~32'h0000_FF03) | (wdata & 32'h0000_FF03);
      if (addr == 8'h68) n_ipsw = wdata[9:8];
      if (addr == 8'h70) n_epc = wdata;
    end
  endtask

  task automatic step();
    m_tick();
    @(posedge clk);
    #1;
    m_badv = n_badv; m_count = n_count; m_cmp = n_cmp; m_epc = n_epc; m_status = n_status;
    m_target = n_target; m_bd = n_bd; m_ti = n_ti; m_flush = n_flush; m_ipsw = n_ipsw;
    m_code = n_code; m_hw = n_hw; m_div = n_div;
    wen = 0; exc_valid = 0; eret = 0; exc_badvaddr_valid = 0; exc_bd = 0;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic rd(input logic [7:0] a, output logic [31:0] v);
    addr = a;
    #1;
    v = rdata;
  endtask

  task automatic check_all(input string tag);
    logic [31:0] v;
    logic [7:0]  list [9];
    list = '{8'h40, 8'h48, 8'h58, 8'h60, 8'h68, 8'h70, 8'h78, 8'h80, 8'h61};
    foreach (list[i]) begin
      rd(list[i], v);
      chk($sformatf("%s rd%02h", tag, list[i]), v, m_read(list[i]));
    end
    chk({tag, " int_pending"}, {31'd0, int_pending}, {31'd0, m_int()});
    chk({tag, " flush"}, {31'd0, flush}, {31'd0, m_flush});
    chk({tag, " exl"}, {31'd0, status_exl}, {31'd0, m_status[1]});
    if (m_flush) chk({tag, " target"}, exc_target, m_target);
  endtask

  task automatic mtc0(input logic [7:0] a, input logic [31:0] d);
    wen = 1; addr = a; wdata = d;
    step();
  endtask

  initial begin
    logic [31:0] v;
    logic [7:0]  alist [10];
    alist = '{8'h40, 8'h48, 8'h58, 8'h60, 8'h68, 8'h70, 8'h78, 8'h80, 8'h49, 8'hFF};

    // Reset held for 3 cycles; values checked while reset is asserted.
    m_reset();
    repeat (3) @(posedge clk);
    #1;
    rd(8'h60, v); chk("reset status", v, 32'h0040_0000);
    rd(8'h48, v); chk("reset count", v, 32'h0);
    rd(8'h58, v); chk("reset compare", v, 32'h0);
    rd(8'h68, v); chk("reset cause", v, 32'h0);
    chk("reset flush", {31'd0, flush}, 32'h0);
    chk("reset target", exc_target, 32'h0);
    resetn = 1;
    step(); check_all("post_reset");

    // Count wrap through the divider.
    mtc0(8'h48, 32'hFFFF_FFFE); check_all("cnt_wr");
    repeat (4) begin step(); check_all("cnt_run"); end
    rd(8'h48, v); chk("count wrap", v, 32'h0000_0000);
    step();
    mtc0(8'h48, 32'h1234_5678);
    rd(8'h48, v); chk("count write beats inc", v, 32'h1234_5678);
    check_all("cnt_exact");

    // Timer interrupt.
    mtc0(8'h58, 32'd10); check_all("cmp10");
    mtc0(8'h48, 32'd0);
    mtc0(8'h60, 32'h0000_8001); check_all("status_wr");
    repeat (24) begin step(); check_all("timer"); end
    rd(8'h68, v); chk("ti set", {31'd0, v[30]}, 32'd1);
    chk("timer int", {31'd0, int_pending}, 32'd1);
    mtc0(8'h58, 32'd20);
    rd(8'h68, v); chk("ti cleared", {31'd0, v[30]}, 32'd0);
    chk("timer int cleared", {31'd0, int_pending}, 32'd0);
    check_all("cmp20");

    // Delay-slot exception.
    exc_valid = 1; exc_bd = 1; exc_pc = 32'hBFC0_0104; exc_code = 5'h04;
    exc_badvaddr = 32'h1234_5679; exc_badvaddr_valid = 1;
    step();
    rd(8'h70, v); chk("ds epc", v, 32'hBFC0_0100);
    rd(8'h68, v); chk("ds bd", {31'd0, v[31]}, 32'd1);
    chk("ds exccode", {27'd0, v[6:2]}, 32'd4);
    rd(8'h40, v); chk("ds badvaddr", v, 32'h1234_5679);
    chk("ds exl", {31'd0, status_exl}, 32'd1);
    chk("ds flush", {31'd0, flush}, 32'd1);
    chk("ds target", exc_target, 32'hBFC0_0380);
    check_all("ds");

    // Nested exception leaves EPC alone, then ERET returns to it.
    exc_valid = 1; exc_pc = 32'h8000_0000; exc_code = 5'h0A;
    step();
    rd(8'h70, v); chk("nested epc", v, 32'hBFC0_0100);
    check_all("nested");
    step(); check_all("idle");
    chk("flush drops", {31'd0, flush}, 32'd0);
    eret = 1;
    step();
    chk("eret flush", {31'd0, flush}, 32'd1);
    chk("eret target", exc_target, 32'hBFC0_0100);
    chk("eret exl", {31'd0, status_exl}, 32'd0);
    check_all("eret");

    // exc_valid beats eret beats wen.
    exc_valid = 1; eret = 1; wen = 1; addr = 8'h60; wdata = 32'h0; exc_pc = 32'h8000_0010;
    step();
    rd(8'h60, v); chk("prio ie kept", {31'd0, v[0]}, 32'd1);
    chk("prio target", exc_target, EXC_VECTOR);
    check_all("prio");

    // Asynchronous reset kills a pending flush at once.
    eret = 1;
    step();
    chk("pre reset flush", {31'd0, flush}, 32'd1);
    resetn = 0;
    #1;
    chk("async rst flush", {31'd0, flush}, 32'd0);
    rd(8'h60, v); chk("async rst status", v, 32'h0040_0000);
    rd(8'h70, v); chk("async rst epc", v, 32'h0);
    m_reset();
    @(posedge clk);
    #1;
    resetn = 1;

    // Randomized traffic against the model.
    for (int i = 0; i < 300; i++) begin
      hw_int = ($urandom_range(0, 3) == 0) ? 6'($urandom) : hw_int;
      wen = ($urandom_range(0, 2) == 0);
      addr = alist[$urandom_range(0, 9)];
      wdata = ($urandom_range(0, 3) == 0) ? m_count + 32'($urandom_range(0, 3)) : $urandom;
      exc_valid = ($urandom_range(0, 15) == 0);
      eret = ($urandom_range(0, 15) == 0);
      exc_bd = $urandom_range(0, 1);
      exc_code = 5'($urandom);
      exc_pc = $urandom;
      exc_badvaddr = $urandom;
      exc_badvaddr_valid = $urandom_range(0, 1);
      step();
      check_all("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cp0_regfile.md
Name: cp0_regfile

Overview:
- Parametrised successor to the baseline CP0 register array for the MIPS pipeline.
- Implements the architecturally defined CP0 subset: BadVAddr, Count, Compare, Status, Cause and EPC.
- Adds a Count/Compare timer, interrupt pending logic, exception entry and ERET handling.
- Sits beside the writeback stage. MTC0/MFC0 use the wen/addr/wdata/rdata port. The commit stage reports exceptions and ERET, and this block returns a registered flush plus the redirect target.

Parameters:
- HW_INT_NUM, 6: number of hardware interrupt inputs (1..6); lines above HW_INT_NUM read as 0.
- COUNT_DIV, 2: Count increments once every COUNT_DIV clk cycles (1..16).
- EXC_VECTOR, 32'hBFC00380: exception entry address driven on exc_target.

Ports:
- clk  in  1  system clock, rising edge.
- resetn  in  1  asynchronous, active-low reset.
- wen  in  1  MTC0 write strobe.
- addr  in  8  register select, {rd[4:0], sel[2:0]}.
- wdata  in  32  MTC0 data.
- rdata  out  32  MFC0 data; combinational from addr.
- hw_int  in  HW_INT_NUM  level-sensitive hardware interrupt lines.
- exc_valid  in  1  commit-stage exception strobe.
- exc_code  in  5  ExcCode of the reported exception.
- exc_bd  in  1  excepting instruction is in a delay slot.
- exc_pc  in  32  PC of the excepting instruction.
- exc_badvaddr  in  32  faulting address.
- exc_badvaddr_valid  in  1  load BadVAddr on this exception.
- eret  in  1  ERET committed.
- int_pending  out  1  interrupt should be taken; combinational.
- flush  out  1  pipeline flush, registered.
- exc_target  out  32  redirect PC, valid while flush=1.
- status_exl  out  1  Status.EXL.

Behaviour:
- Register map (rd,sel):
  - BadVAddr (8,0): read-only to software.
  - Count (9,0).
  - Compare (11,0).
  - Status (12,0).
  - Cause (13,0).
  - EPC (14,0).
  - All other addresses read 0 and ignore writes.
- Reset values (async on resetn low):
  - Status = 32'h0040_0000 (BEV=1, read-only).
  - Cause, Count, Compare, EPC, BadVAddr = 0.
  - Divider counter = 0.
  - flush = 0, exc_target = 0.
- Writable bits:
  - Status: IM[15:8], EXL[1], IE[0].
  - Cause: IP[9:8] only.
  - Count, Compare, EPC: all 32 bits.
- Cause.IP[15:10] is sampled every cycle from hw_int, zero-extended to 6 bits.
- Cause.IP[15] = hw_int[5] | Cause.TI when HW_INT_NUM=6; otherwise IP[15] = TI.
- Count and divider:
  - Divider counts 0..COUNT_DIV-1; Count += 1 (mod 2^32) when the divider wraps.
  - An MTC0 to Count wins over the increment, loads wdata and clears the divider.
- Timer interrupt:
  - Cause.TI (bit 30) is set the cycle after Count==Compare.
  - TI stays set until an MTC0 to Compare clears it.
  - An MTC0 to Compare in the same cycle as the equality leaves TI clear.
- int_pending = Status.IE & ~Status.EXL & |(Cause.IP[15:8] & Status.IM).
- Exception entry (exc_valid=1), applied on the next edge:
  - If EXL=0: EPC <= exc_bd ? exc_pc-4 : exc_pc, and Cause.BD <= exc_bd.
  - If EXL=1: EPC and BD are unchanged.
  - Always: ExcCode[6:2] <= exc_code and EXL <= 1.
  - BadVAddr <= exc_badvaddr only when exc_badvaddr_valid=1.
  - flush=1 for exactly one cycle with exc_target = EXC_VECTOR.
- ERET (eret=1, exc_valid=0), applied on the next edge:
  - EXL <= 0.
  - flush=1 for one cycle with exc_target = EPC value before the edge.
- Priority within one cycle: exc_valid > eret > wen.
  - A wen coincident with exc_valid or eret is dropped.
  - Hardware updates (Count, TI, IP[15:10]) still occur unless they are directly overwritten.
- rdata returns the current registered value, with no write bypass.
- flush is low in every cycle not following an exc_valid or eret.
- Reset asserted mid-operation clears everything immediately, including a pending flush.

Optional Feature:
- Macro: CP0_PRID_CONFIG_EN.
- Defined: adds read-only PRId (15,0) = 32'h0000_4220 and Config (16,0) = 32'h8000_0483; writes to them are ignored.
- Undefined: both addresses read 0, and no extra logic is generated.

Test Plan:
- Reset:
  - Hold resetn=0 for 3 cycles, then release.
  - Read Status -> 32'h0040_0000. Read Count, Compare and Cause -> 0. flush=0.
- Count divider:
  - COUNT_DIV=2: write Count=32'hFFFF_FFFE, wait 4 cycles -> Count=32'h0000_0000, showing wrap.
  - A write in the same cycle as an increment loads wdata exactly.
- Timer interrupt:
  - Write Compare=10, Count=0, Status=32'h0000_8001 (IM7, IE); wait -> TI=1 one cycle after Count==10, int_pending=1.
  - Write Compare=20 -> TI=0, int_pending=0.
- Delay-slot exception:
  - exc_valid=1, exc_bd=1, exc_pc=32'hBFC0_0104, exc_code=5'h04, badvaddr valid=32'h1234_5679.
  - Next cycle: EPC=32'hBFC0_0100, BD=1, ExcCode=4, EXL=1, BadVAddr=32'h1234_5679, flush=1, exc_target=32'hBFC0_0380.
- Nested exception and ERET:
  - With EXL=1, second exception exc_pc=32'h8000_0000 -> EPC unchanged.
  - Then eret -> flush=1, exc_target=old EPC, EXL=0.
- Priority:
  - exc_valid, eret and wen (Status=0) in the same cycle -> exception taken, Status.IE unchanged, flush target=EXC_VECTOR.
